// File: rtl/fetch_seq_pkg.sv
// Shared types and constants for the fetch sequencer: command opcodes,
// FSM states, PE routing codes and the default watchdog limit.
package fetch_seq_pkg;

  typedef enum logic [2:0] {
    OP_LOAD_BCAST = 3'd0,
    OP_LOAD_PE    = 3'd1,
    OP_LOADA      = 3'd2,
    OP_LOADB      = 3'd3,
    OP_STORE      = 3'd4
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_e;

  // PE_SEL routing codes presented to the fetch unit
  localparam logic [1:0] SEL_BCAST  = 2'd0;
  localparam logic [1:0] SEL_SINGLE = 2'd1;
  localparam logic [1:0] SEL_ROWS   = 2'd2;
  localparam logic [1:0] SEL_COLS   = 2'd3;

  localparam int TIMEOUT_CYCLES_DEF = 32;

  // Opcodes 5..7 are reserved and answered with an error response
  function automatic logic op_legal(input logic [2:0] op);
    return (op <= 3'd4);
  endfunction

endpackage

// File: rtl/fetch_seq_watchdog.sv
// Loadable down-counter used as the RUN-state watchdog of fetch_sequencer.
// Loaded with the limit minus one; o_expired flags the last permitted RUN cycle.
module fetch_seq_watchdog
  import fetch_seq_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_load,
  input  logic i_run,
  output logic o_expired
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CW-1:0] r_cnt;

  // Reload on entry to the command, count down while the fetch is running
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= CW'(TIMEOUT_CYCLES - 1);
    end else if (i_run && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_expired = i_run && (r_cnt == '0);

endmodule

// File: rtl/fetch_sequencer.sv
// Command-driven sequencer for the BRAM fetch unit feeding the PE array.
// Optional RUN-state watchdog enabled by defining FETCH_SEQ_TIMEOUT_EN.
module fetch_sequencer
  import fetch_seq_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       CMD_VALID,
  output logic       CMD_READY,
  input  logic [2:0] CMD_OP,
  input  logic [1:0] CMD_DIMEN,
  input  logic [3:0] CMD_BASE,
  input  logic [1:0] CMD_PE,
  output logic       RSP_VALID,
  output logic       RSP_ERR,
  output logic       PE_LD,
  output logic       ADDR_START,
  output logic       ADDR_RST,
  output logic       WRADDR_START,
  output logic [1:0] DIMEN,
  output logic [3:0] ADDRESS,
  output logic [1:0] PE_SEL,
  output logic       PE_SEL_2x2,
  output logic       PE_SEL_4,
  input  logic       FETCH_DONE,
  input  logic       STORE_DONE
);

  state_e     r_state;
  state_e     w_next;
  op_e        r_op;
  logic [1:0] r_dimen;
  logic [3:0] r_addr;
  logic [1:0] r_route_sel;
  logic       r_sel_2x2;
  logic       r_sel_4;
  logic [1:0] r_word_idx;
  logic       r_err;
  logic       r_pe_ld;
  logic       w_is_store;
  logic       w_done_hit;
  logic       w_timeout;
  logic       w_expired;

  assign w_is_store = (r_op == OP_STORE);

`ifdef FETCH_SEQ_TIMEOUT_EN
  fetch_seq_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .i_clk     (CLK),
    .i_rst     (RST),
    .i_load    (r_state == S_CLEAR),
    .i_run     (r_state == S_RUN),
    .o_expired (w_expired)
  );
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
  assign w_expired        = 1'b0;
`endif

  // Next-state decode and fetch-unit strobes; strobes are held low during reset
  always_comb begin
    w_next       = r_state;
    w_done_hit   = 1'b0;
    w_timeout    = 1'b0;
    CMD_READY    = 1'b0;
    ADDR_RST     = RST;
    ADDR_START   = 1'b0;
    WRADDR_START = 1'b0;
    RSP_VALID    = 1'b0;
    RSP_ERR      = 1'b0;
    PE_LD        = r_pe_ld;
    DIMEN        = r_dimen;
    ADDRESS      = r_addr;
    PE_SEL       = r_route_sel;
    PE_SEL_2x2   = r_sel_2x2;
    PE_SEL_4     = r_sel_4;
    case (r_state)
      S_IDLE: begin
        CMD_READY = !RST;
        if (CMD_VALID) begin
          w_next = op_legal(CMD_OP) ? S_CLEAR : S_DONE;
        end
      end
      S_CLEAR: begin
        ADDR_RST = 1'b1;
        w_next   = S_RUN;
      end
      S_RUN: begin
        ADDR_START = !RST;
        if (w_is_store) begin
          WRADDR_START = !RST;
          PE_SEL       = r_word_idx;
          w_done_hit   = STORE_DONE;
        end else begin
          w_done_hit   = FETCH_DONE;
        end
        // A terminal count arriving on the expiry cycle still counts as success
        w_timeout = w_expired && !w_done_hit;
        if (w_done_hit) begin
          w_next = w_is_store ? S_DONE : S_DRAIN;
        end else if (w_timeout) begin
          w_next = S_DONE;
        end
      end
      S_DRAIN: begin
        ADDR_START = !RST;
        w_next     = S_DONE;
      end
      S_DONE: begin
        RSP_VALID = !RST;
        RSP_ERR   = !RST && r_err;
        w_next    = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // State register, command latch, store word index and delayed load strobe
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= S_IDLE;
      r_op        <= OP_LOAD_BCAST;
      r_dimen     <= '0;
      r_addr      <= '0;
      r_route_sel <= SEL_BCAST;
      r_sel_2x2   <= 1'b0;
      r_sel_4     <= 1'b0;
      r_word_idx  <= '0;
      r_err       <= 1'b0;
      r_pe_ld     <= 1'b0;
    end else begin
      r_state <= w_next;
      // BRAM data lands one cycle after its address, so the PE strobe lags RUN
      r_pe_ld <= (r_state == S_RUN) && !w_is_store && !w_timeout;
      if ((r_state == S_IDLE) && CMD_VALID) begin
        r_err <= !op_legal(CMD_OP);
        if (op_legal(CMD_OP)) begin
          r_op       <= op_e'(CMD_OP);
          r_dimen    <= CMD_DIMEN;
          r_addr     <= CMD_BASE;
          r_word_idx <= '0;
          case (op_e'(CMD_OP))
            OP_LOAD_PE: begin
              r_route_sel <= SEL_SINGLE;
              r_sel_4     <= CMD_PE[1];
              r_sel_2x2   <= CMD_PE[0];
            end
            OP_LOADA: begin
              r_route_sel <= SEL_ROWS;
              r_sel_4     <= 1'b0;
              r_sel_2x2   <= CMD_PE[0];
            end
            OP_LOADB: begin
              r_route_sel <= SEL_COLS;
              r_sel_4     <= 1'b0;
              r_sel_2x2   <= CMD_PE[0];
            end
            default: begin
              r_route_sel <= SEL_BCAST;
              r_sel_4     <= 1'b0;
              r_sel_2x2   <= 1'b0;
            end
          endcase
        end
      end else if ((r_state == S_RUN) && w_is_store) begin
        r_word_idx <= r_word_idx + 1'b1;
      end
      if (w_timeout) begin
        r_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: commands push their expected timeline
// into a queue; a negedge monitor checks strobes and responses against it.
module tb_fetch_sequencer;

  localparam int TB_TC = 12;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       CMD_VALID = 1'b0;
  logic       CMD_READY;
  logic [2:0] CMD_OP = '0;
  logic [1:0] CMD_DIMEN = '0;
  logic [3:0] CMD_BASE = '0;
  logic [1:0] CMD_PE = '0;
  logic       RSP_VALID, RSP_ERR, PE_LD, ADDR_START, ADDR_RST, WRADDR_START;
  logic [1:0] DIMEN;
  logic [3:0] ADDRESS;
  logic [1:0] PE_SEL;
  logic       PE_SEL_2x2, PE_SEL_4;
  logic       FETCH_DONE, STORE_DONE;

  fetch_sequencer #(.TIMEOUT_CYCLES(TB_TC)) dut (
    .CLK(CLK), .RST(RST), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
    .CMD_OP(CMD_OP), .CMD_DIMEN(CMD_DIMEN), .CMD_BASE(CMD_BASE), .CMD_PE(CMD_PE),
    .RSP_VALID(RSP_VALID), .RSP_ERR(RSP_ERR), .PE_LD(PE_LD),
    .ADDR_START(ADDR_START), .ADDR_RST(ADDR_RST), .WRADDR_START(WRADDR_START),
    .DIMEN(DIMEN), .ADDRESS(ADDRESS), .PE_SEL(PE_SEL), .PE_SEL_2x2(PE_SEL_2x2),
    .PE_SEL_4(PE_SEL_4), .FETCH_DONE(FETCH_DONE), .STORE_DONE(STORE_DONE)
  );

  initial forever #5 CLK = ~CLK;

  // kind: 0 load, 1 store, 2 illegal, 3 load that times out
  typedef struct {
    int         t;
    int         kind;
    int         n;
    logic [1:0] dimen;
    logic [3:0] base;
    logic [1:0] sel;
    logic       s2x2;
    logic       s4;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   fm_cnt = 0;
  int   model_n = 2;
  bit   en_done = 1'b1;

  always @(posedge CLK) cyc <= cyc + 1;

  // Fetch-unit model: counts issued addresses and raises the terminal flag on the last one
  always @(posedge CLK) begin
    if (ADDR_RST) fm_cnt <= 0;
    else if (ADDR_START) fm_cnt <= fm_cnt + 1;
  end

  always_comb begin
    FETCH_DONE = en_done && ADDR_START && !WRADDR_START && (fm_cnt == model_n - 1);
    STORE_DONE = en_done && WRADDR_START && (fm_cnt == 3);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, act, exp);
    end
  endtask

  function automatic bit in_rng(input int d, input int lo, input int hi);
    return (d >= lo) && (d <= hi);
  endfunction

  exp_t mon_e;
  int   mon_d, mon_end;
  logic mon_start, mon_ld;

  // Monitor: checks the head command's timeline, and flags stray responses
  always @(negedge CLK) begin
    if (!RST) begin
      if (q.size() == 0) begin
        chk("rsp_unexpected", RSP_VALID, 0);
      end else begin
        mon_e = q[0];
        mon_d = cyc - mon_e.t;
        case (mon_e.kind)
          0: mon_end = 3 + mon_e.n;
          1: mon_end = 6;
          2: mon_end = 1;
          default: mon_end = TB_TC + 2;
        endcase
        case (mon_e.kind)
          0: begin mon_start = in_rng(mon_d, 2, 2 + mon_e.n); mon_ld = in_rng(mon_d, 3, 2 + mon_e.n); end
          1: begin mon_start = in_rng(mon_d, 2, 5); mon_ld = 1'b0; end
          2: begin mon_start = 1'b0; mon_ld = 1'b0; end
          default: begin mon_start = in_rng(mon_d, 2, TB_TC + 1); mon_ld = in_rng(mon_d, 3, TB_TC + 1); end
        endcase
        chk("cmd_ready", CMD_READY, (mon_d == 0));
        chk("addr_rst", ADDR_RST, (mon_d == 1) && (mon_e.kind != 2));
        chk("addr_start", ADDR_START, mon_start);
        chk("wraddr_start", WRADDR_START, (mon_e.kind == 1) && in_rng(mon_d, 2, 5));
        chk("pe_ld", PE_LD, mon_ld);
        if ((mon_e.kind != 2) && (mon_d >= 1)) begin
          chk("address", ADDRESS, mon_e.base);
          if (mon_e.kind != 1) begin
            chk("dimen", DIMEN, mon_e.dimen);
            chk("pe_sel", PE_SEL, mon_e.sel);
            chk("pe_sel_2x2", PE_SEL_2x2, mon_e.s2x2);
            chk("pe_sel_4", PE_SEL_4, mon_e.s4);
          end else if (in_rng(mon_d, 2, 5)) begin
            chk("store_pe_sel", PE_SEL, mon_d - 2);
          end
        end
        chk("rsp_valid", RSP_VALID, (mon_d == mon_end));
        if (mon_d >= mon_end) begin
          chk("rsp_err", RSP_ERR, (mon_e.kind >= 2));
          void'(q.pop_front());
        end
      end
    end
  end

  // Offer one command; caller is positioned just after a rising edge
  task automatic issue(input logic [2:0] op, input logic [1:0] dimen, input logic [3:0] base,
                       input logic [1:0] pe, input int kind, input int n, input logic [1:0] sel,
                       input logic s2x2, input logic s4, input bit push, output int t);
    exp_t e;
    int   guard = 0;
    t = -1;
    while (!CMD_READY) begin
      @(posedge CLK); #1;
      guard++;
      if (guard > 200) begin
        chk("issue_ready_timeout", CMD_READY, 1);
        return;
      end
    end
    CMD_VALID = 1'b1;
    CMD_OP    = op;
    CMD_DIMEN = dimen;
    CMD_BASE  = base;
    CMD_PE    = pe;
    model_n   = n;
    t         = cyc;
    if (push) begin
      e.t = cyc; e.kind = kind; e.n = n; e.dimen = dimen; e.base = base;
      e.sel = sel; e.s2x2 = s2x2; e.s4 = s4;
      q.push_back(e);
    end
    @(posedge CLK); #1;
    CMD_VALID = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while ((q.size() != 0) || !CMD_READY) begin
      @(posedge CLK); #1;
      k++;
      if (k > budget) begin
        chk("wait_idle_timeout", q.size(), 0);
        q.delete();
        return;
      end
    end
  endtask

  int t1, t2, tr;

  initial begin
    repeat (3) @(posedge CLK);
    #1;
    chk("reset_addr_rst", ADDR_RST, 1);
    chk("reset_cmd_ready", CMD_READY, 0);
    chk("reset_addr_start", ADDR_START, 0);
    chk("reset_pe_ld", PE_LD, 0);
    chk("reset_rsp_valid", RSP_VALID, 0);
    chk("reset_address", ADDRESS, 0);
    chk("reset_pe_sel", PE_SEL, 0);
    RST = 1'b0;
    @(posedge CLK); #1;
    chk("post_reset_ready", CMD_READY, 1);
    chk("post_reset_addr_rst", ADDR_RST, 0);

    // LOAD_BCAST DIMEN=1 BASE=4: N=4, response 7 cycles after accept
    issue(3'd0, 2'd1, 4'd4, 2'd0, 0, 4, 2'd0, 1'b0, 1'b0, 1'b1, t1);
    wait_idle(50);
    // LOAD_PE to PE 2, DIMEN=0: PE_SEL=1, PE_SEL_4=1, PE_SEL_2x2=0, two PE_LD pulses
    issue(3'd1, 2'd0, 4'd9, 2'd2, 0, 2, 2'd1, 1'b0, 1'b1, 1'b1, t1);
    wait_idle(50);
    // LOADA half 1, DIMEN=2 (N=8)
    issue(3'd2, 2'd2, 4'd3, 2'd1, 0, 8, 2'd2, 1'b1, 1'b0, 1'b1, t1);
    wait_idle(50);
    // LOADB half 0, DIMEN=0, top address
    issue(3'd3, 2'd0, 4'd15, 2'd2, 0, 2, 2'd3, 1'b0, 1'b0, 1'b1, t1);
    wait_idle(50);
    // STORE BASE=8: four write cycles, PE_SEL 0..3
    issue(3'd4, 2'd3, 4'd8, 2'd0, 1, 4, 2'd0, 1'b0, 1'b0, 1'b1, t1);
    wait_idle(50);
    // Illegal opcode 6: immediate error response
    issue(3'd6, 2'd0, 4'd0, 2'd0, 2, 2, 2'd0, 1'b0, 1'b0, 1'b1, t1);
    wait_idle(50);

    // Back-to-back: second accept lands on the cycle after DONE (N=2 -> 6 cycles)
    issue(3'd0, 2'd0, 4'd1, 2'd0, 0, 2, 2'd0, 1'b0, 1'b0, 1'b1, t1);
    issue(3'd7, 2'd0, 4'd0, 2'd0, 2, 2, 2'd0, 1'b0, 1'b0, 1'b1, t2);
    chk("b2b_gap_load", t2 - t1, 6);
    issue(3'd3, 2'd1, 4'd6, 2'd3, 0, 4, 2'd3, 1'b1, 1'b0, 1'b1, t1);
    chk("b2b_gap_illegal", t1 - t2, 2);
    wait_idle(50);

    // Reset at T+4 of a DIMEN=3 load drops the command
    issue(3'd0, 2'd3, 4'd2, 2'd0, 0, 16, 2'd0, 1'b0, 1'b0, 1'b0, tr);
    while (cyc < tr + 4) begin @(posedge CLK); #1; end
    RST = 1'b1;
    @(posedge CLK); #1;
    chk("midrst_addr_rst", ADDR_RST, 1);
    chk("midrst_addr_start", ADDR_START, 0);
    chk("midrst_rsp_valid", RSP_VALID, 0);
    @(posedge CLK); #1;
    chk("midrst_pe_ld", PE_LD, 0);
    chk("midrst_ready", CMD_READY, 0);
    RST = 1'b0;
    @(posedge CLK); #1;
    chk("midrst_idle_ready", CMD_READY, 1);
    chk("midrst_idle_rsp", RSP_VALID, 0);
    issue(3'd4, 2'd0, 4'd5, 2'd0, 1, 4, 2'd0, 1'b0, 1'b0, 1'b1, t1);
    wait_idle(50);

    // Fetch unit never signals completion
    en_done = 1'b0;
`ifdef FETCH_SEQ_TIMEOUT_EN
    issue(3'd0, 2'd0, 4'd0, 2'd0, 3, 2, 2'd0, 1'b0, 1'b0, 1'b1, t1);
    wait_idle(TB_TC + 20);
`else
    issue(3'd0, 2'd0, 4'd0, 2'd0, 0, 2, 2'd0, 1'b0, 1'b0, 1'b0, t1);
    repeat (40) @(posedge CLK);
    #1;
    chk("stuck_addr_start", ADDR_START, 1);
    chk("stuck_ready", CMD_READY, 0);
    chk("stuck_pe_ld", PE_LD, 1);
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    @(posedge CLK); #1;
    chk("stuck_recover_ready", CMD_READY, 1);
`endif
    en_done = 1'b1;
    repeat (3) @(posedge CLK);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout cyc=%0d actual=running required=finished", cyc);
    $fatal(1, "bench time limit");
  end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Command-driven controller that sequences the BRAM data-fetch unit for the PE array. It accepts one LOAD/LOADA/LOADB/STORE command at a time from the instruction control unit and drives the fetch unit's counter-control, dimension, base-address and PE-routing inputs. It absorbs the one-cycle BRAM read latency, so the PE array receives an explicit load strobe. It reports completion with a one-cycle response pulse.

## Interface
Parameters:
- TIMEOUT_CYCLES, 32, watchdog limit in RUN state (used only with `FETCH_SEQ_TIMEOUT_EN`).

Ports:
- CLK  in  1  single clock; all logic on posedge.
- RST  in  1  synchronous, active-high reset.
- CMD_VALID  in  1  command offered.
- CMD_READY  out  1  high only in IDLE.
- CMD_OP  in  3  0 LOAD_BCAST, 1 LOAD_PE, 2 LOADA, 3 LOADB, 4 STORE, 5-7 illegal.
- CMD_DIMEN  in  2  load length code; word count N = 2^(DIMEN+1) (2/4/8/16).
- CMD_BASE  in  4  BRAM base address.
- CMD_PE  in  2  LOAD_PE: target PE 0-3; LOADA/LOADB: bit0 = half select; otherwise ignored.
- RSP_VALID  out  1  one-cycle completion pulse.
- RSP_ERR  out  1  valid with RSP_VALID; 1 = illegal op or timeout.
- PE_LD  out  1  PE capture strobe; the fetch data bus is valid this cycle.
- ADDR_START, ADDR_RST, WRADDR_START  out  1 each  fetch-unit counter and write control.
- DIMEN  out  2, ADDRESS  out  4, PE_SEL  out  2, PE_SEL_2x2  out  1, PE_SEL_4  out  1  fetch-unit configuration.
- FETCH_DONE, STORE_DONE  in  1 each  fetch-unit terminal-count flags.

## Operation
- States: IDLE, CLEAR, RUN, DRAIN, DONE.
- IDLE: CMD_READY=1.
  - Legal accept (CMD_VALID & CMD_READY): latch the command and go to CLEAR.
  - Illegal op accepted: go to DONE with RSP_ERR=1; no fetch-unit activity.
- CLEAR: ADDR_RST=1 for exactly one cycle, then RUN.
- RUN, loads: ADDR_START=1.
  - Exit to DRAIN on the cycle FETCH_DONE=1; that cycle still issues its address.
- RUN, STORE: ADDR_START=1 and WRADDR_START=1.
  - PE_SEL = internal word index 0,1,2,3, incrementing each RUN cycle, so word k from PE k is written to BASE+k.
  - Exit to DONE on the cycle STORE_DONE=1; that cycle's write still occurs.
- DRAIN: ADDR_START=1 for one cycle so the last read word is driven onto the fetch data bus; then DONE.
- DONE: RSP_VALID=1 for one cycle, then IDLE. There is no response backpressure.
- PE_LD = registered (state==RUN & load op), i.e. high the cycle after each load address issue.
- Routing, latched at accept and stable for the whole command:
  - LOAD_BCAST: PE_SEL=0.
  - LOAD_PE: PE_SEL=1, {PE_SEL_4, PE_SEL_2x2} = CMD_PE.
  - LOADA: PE_SEL=2, PE_SEL_2x2 = CMD_PE[0].
  - LOADB: PE_SEL=3, PE_SEL_2x2 = CMD_PE[0].
- DIMEN = CMD_DIMEN and ADDRESS = CMD_BASE, both latched at accept. STORE ignores DIMEN.
- CMD_VALID while busy is ignored (CMD_READY=0).

## Timing
- Reset values: all outputs 0 except ADDR_RST=1 while RST is high. State resets to IDLE.
- RST mid-command: IDLE on the next cycle, all strobes low, no RSP_VALID; the command is dropped.
- Load accepted at cycle T, N words:
  - CLEAR at T+1.
  - RUN at T+2..T+1+N.
  - DRAIN at T+2+N.
  - PE_LD at T+3..T+2+N (N pulses).
  - RSP_VALID at T+3+N.
  - CMD_READY again at T+4+N.
- STORE accepted at T: RUN at T+2..T+5, PE_SEL 0..3, RSP_VALID at T+6.
- Illegal op accepted at T: RSP_VALID=RSP_ERR=1 at T+1.
- Back-to-back: the next accept is possible in the cycle after DONE.

## Configuration
- `FETCH_SEQ_TIMEOUT_EN` defined:
  - A cycle counter runs in RUN.
  - If no FETCH_DONE/STORE_DONE arrives within TIMEOUT_CYCLES, go to DONE with RSP_ERR=1 and skip DRAIN; PE_LD stops.
- Undefined: no counter; RUN waits indefinitely, and RSP_ERR is set only for illegal ops.

## Structure
- Package fetch_seq_pkg holds:
  - op enum (LOAD_BCAST..STORE),
  - state enum,
  - PE_SEL encoding constants (SEL_BCAST, SEL_SINGLE, SEL_ROWS, SEL_COLS),
  - default TIMEOUT_CYCLES.
- One sub-module, fetch_seq_watchdog: a loadable down-counter with expire flag, instantiated only under `FETCH_SEQ_TIMEOUT_EN`.

## Test plan
- LOAD_BCAST, DIMEN=1, BASE=4 at T:
  - ADDR_RST at T+1; ADDR_START T+2..T+6; FETCH_DONE modelled at T+5.
  - PE_LD T+3..T+6 with PE_SEL=0; RSP_VALID at T+7 with RSP_ERR=0.
- LOAD_PE, CMD_PE=2, DIMEN=0: PE_SEL=1, PE_SEL_4=1, PE_SEL_2x2=0 throughout; exactly 2 PE_LD pulses.
- STORE, BASE=8: WRADDR_START at T+2..T+5, PE_SEL 0,1,2,3, ADDRESS=8; RSP_VALID at T+6.
- CMD_OP=6: no ADDR_RST/ADDR_START; RSP_VALID=RSP_ERR=1 at T+1.
- RST asserted at T+4 of a DIMEN=3 load: state returns to IDLE, ADDR_RST=1 during reset, no RSP_VALID, and a fresh command is accepted after reset.
- With `FETCH_SEQ_TIMEOUT_EN` and FETCH_DONE held low: RSP_ERR=1 TIMEOUT_CYCLES+2 cycles after accept (CLEAR at T+1, RUN from T+2, DONE once the limit expires, no DRAIN); without the macro, the block stays in RUN.
